// File: rtl/filter_pkg.sv
// Shared definitions for the moving-average filter feeder: sample width,
// filter geometry and the feeder FSM state type.
package filter_pkg;

    localparam int SAMPLE_W       = 8;
    localparam int FILTER_TAPS    = 4;
    localparam int FILTER_LATENCY = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO. Pointers carry one extra MSB so full and empty
// are told apart without a separate counter; occupancy is their difference.
// Pushes while full and pops while empty are ignored internally.
module sample_fifo #(
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = 8
) (
    input  logic                   CLK100MHZ,
    input  logic                   reset,
    input  logic                   push,
    input  logic [SAMPLE_W-1:0]    wr_data,
    input  logic                   pop,
    output logic [SAMPLE_W-1:0]    rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = 1;

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 wr_en;
    logic                 rd_en;
    logic [SAMPLE_W-1:0]  mem_q [DEPTH];

    // Status flags, gated handshakes and next pointer values.
    // NOTE: every signal gets a default at the top so no path can infer a latch.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level    = wr_ptr_q - rd_ptr_q;
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers with synchronous reset.
    // NOTE: clocked state uses <= so every flop updates from pre-edge values.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage write port.
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge CLK100MHZ) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/filter_feeder.sv
// Streaming driver for the 4-tap moving-average filter. Buffers incoming
// samples, issues them to the filter with a start strobe, and captures the
// filter result one cycle later as a valid-qualified output stream.
// Optional build macro FILTER_FEEDER_PRIME_EN suppresses the first three
// results of every run so only full four-sample averages are emitted.
module filter_feeder
    import filter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       CLK100MHZ,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [SAMPLE_W-1:0] flt_sample,
    output logic                       flt_start,
    input  logic signed [SAMPLE_W-1:0] flt_result,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [SAMPLE_W-1:0]        fifo_rd_data;
    logic                       issue_ok;

    feeder_state_t              state_q, state_d;
    logic signed [SAMPLE_W-1:0] flt_sample_q, flt_sample_d;
    logic                       flt_start_q, flt_start_d;
    logic [FILTER_LATENCY-1:0]  issue_q, issue_d;
    logic signed [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
`ifdef FILTER_FEEDER_PRIME_EN
    localparam logic [1:0]      PRIME_DONE = 2'(FILTER_TAPS - 1);
    logic [1:0]                 prime_cnt_q, prime_cnt_d;
`endif

    sample_fifo #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W)
    ) u_fifo (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .push      (in_valid),
        .wr_data   (in_data),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Issue FSM: pop one sample per edge while data is queued and enabled.
    always_comb begin
        state_d      = state_q;
        fifo_pop     = 1'b0;
        flt_sample_d = '0;
        flt_start_d  = 1'b0;
        issue_ok     = enable && !fifo_empty;
        case (state_q)
            IDLE: begin
                if (issue_ok) state_d = RUN;
            end
            RUN: begin
                if (!issue_ok) state_d = IDLE;
            end
        endcase
        if (issue_ok) begin
            fifo_pop     = 1'b1;
            flt_sample_d = $signed(fifo_rd_data);
            flt_start_d  = 1'b1;
        end
    end

    // Result capture: the issue pipe lines the strobe up with the filter output.
    always_comb begin
        issue_d     = (issue_q << 1) | FILTER_LATENCY'(flt_start_q);
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (issue_q[FILTER_LATENCY-1]) begin
            out_data_d  = flt_result;
            out_valid_d = 1'b1;
        end
`ifdef FILTER_FEEDER_PRIME_EN
        prime_cnt_d = prime_cnt_q;
        if (issue_q[FILTER_LATENCY-1]) begin
            out_valid_d = (prime_cnt_q == PRIME_DONE);
            if (prime_cnt_q != PRIME_DONE) prime_cnt_d = prime_cnt_q + 2'd1;
        end
        // A new run restarts priming; this wins over a late capture of the old run.
        if (state_q == IDLE && state_d == RUN) prime_cnt_d = '0;
`endif
    end

    // State, issue and capture registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            flt_sample_q <= '0;
            flt_start_q  <= 1'b0;
            issue_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef FILTER_FEEDER_PRIME_EN
            prime_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            flt_sample_q <= flt_sample_d;
            flt_start_q  <= flt_start_d;
            issue_q      <= issue_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
`ifdef FILTER_FEEDER_PRIME_EN
            prime_cnt_q  <= prime_cnt_d;
`endif
        end
    end

    assign in_ready   = !fifo_full;
    assign flt_sample = flt_sample_q;
    assign flt_start  = flt_start_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_filter_feeder.sv
// Bench for filter_feeder with a behavioural 4-tap moving-average filter
// attached. The reference model tracks the queued samples, the stream of
// issued values (zero on idle edges) and predicts each output pulse as the
// floor of the average of the last four issued values, two edges after issue.
module tb_filter_feeder;
    import filter_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_15   = LW'(DEPTH - 1);

    logic                       CLK100MHZ = 1'b0;
    logic                       reset;
    logic                       enable;
    logic signed [SAMPLE_W-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] flt_sample;
    logic                       flt_start;
    logic signed [SAMPLE_W-1:0] flt_result;
    logic signed [SAMPLE_W-1:0] out_data;
    logic                       out_valid;
    logic [LW-1:0]              fifo_level;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    filter_feeder #(.DEPTH(DEPTH)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flt_sample (flt_sample),
        .flt_start  (flt_start),
        .flt_result (flt_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .fifo_level (fifo_level)
    );

    // Attached filter: delay line shifts every clock, result registered once.
    logic signed [SAMPLE_W-1:0] tap0, tap1, tap2;
    logic signed [9:0]          fsum;
    assign fsum = 10'(flt_sample) + 10'(tap0) + 10'(tap1) + 10'(tap2);
    always @(posedge CLK100MHZ) begin
        if (reset) begin
            tap0 <= '0; tap1 <= '0; tap2 <= '0; flt_result <= '0;
        end else begin
            tap0 <= flt_sample; tap1 <= tap0; tap2 <= tap1;
            flt_result <= fsum[9:2];
        end
    end

    // Reference model state
    int q[$];
    int win[4];
    bit pv[2];
    int pd[2];
    bit m_valid;
    int m_data;
`ifdef FILTER_FEEDER_PRIME_EN
    bit prev_pop;
    int run_idx;
`endif

    // Predict the effect of the coming edge from the inputs now applied, then
    // advance to the following falling edge where outputs are sampled.
    task automatic cycle();
        bit do_pop;
        bit do_push;
        int issued;
        if (reset) begin
            q.delete();
            foreach (win[k]) win[k] = 0;
            pv[0] = 0; pv[1] = 0; pd[0] = 0; pd[1] = 0;
            m_valid = 0; m_data = 0;
`ifdef FILTER_FEEDER_PRIME_EN
            prev_pop = 0; run_idx = 0;
`endif
        end else begin
            m_valid = pv[1];
            if (pv[1]) m_data = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            do_pop  = enable && (q.size() > 0);
            do_push = in_valid && (q.size() < DEPTH);
            issued  = do_pop ? q.pop_front() : 0;
            if (do_push) q.push_back(int'(in_data));
            for (int k = 3; k > 0; k--) win[k] = win[k-1];
            win[0] = issued;
            pd[0] = (win[0] + win[1] + win[2] + win[3]) >>> 2;  // floor(sum / 4)
            pv[0] = do_pop;
`ifdef FILTER_FEEDER_PRIME_EN
            if (do_pop && !prev_pop) run_idx = 0;
            if (do_pop) begin
                pv[0] = (run_idx >= 3);
                run_idx++;
            end
            prev_pop = do_pop;
`endif
        end
        @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; in_valid = 0; in_data = '0;
        cycle();
        cycle();
        vectors += 6;
        if (flt_sample !== 8'sd0) begin miscompares++; $display("FAIL reset flt_sample: got %0d, expected 0", flt_sample); end
        if (flt_start !== 1'b0)   begin miscompares++; $display("FAIL reset flt_start: got %b, expected 0", flt_start); end
        if (out_data !== 8'sd0)   begin miscompares++; $display("FAIL reset out_data: got %0d, expected 0", out_data); end
        if (out_valid !== 1'b0)   begin miscompares++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
        if (fifo_level !== '0)    begin miscompares++; $display("FAIL reset fifo_level: got %0d, expected 0", fifo_level); end
        if (in_ready !== 1'b1)    begin miscompares++; $display("FAIL reset in_ready: got %b, expected 1", in_ready); end
        reset = 0;
        cycle();
    endtask

    // 4, 8, 12, 16 back to back: averages 1, 3, 6, 10 starting 3 edges after first accept.
    task automatic test_ramp();
        logic signed [SAMPLE_W-1:0] ramp[4];
        int vals[$]; int edges[$]; int want_v[$]; int want_e[$];
        ramp = '{8'sd4, 8'sd8, 8'sd12, 8'sd16};
`ifdef FILTER_FEEDER_PRIME_EN
        want_v = '{10}; want_e = '{6};
`else
        want_v = '{1, 3, 6, 10}; want_e = '{3, 4, 5, 6};
`endif
        enable = 1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4);
            in_data  = (i < 4) ? ramp[i] : 8'sd0;
            cycle();
            vectors++;
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL ramp out_valid edge %0d: got %b, expected %b", i, out_valid, m_valid); end
            if (out_valid === 1'b1) begin vals.push_back(int'(out_data)); edges.push_back(i); end
        end
        in_valid = 0;
        vectors++;
        if (vals.size() != want_v.size()) begin miscompares++; $display("FAIL ramp pulse_count: got %0d, expected %0d", vals.size(), want_v.size()); end
        for (int k = 0; k < vals.size() && k < want_v.size(); k++) begin
            vectors += 2;
            if (vals[k] != want_v[k])   begin miscompares++; $display("FAIL ramp value[%0d]: got %0d, expected %0d", k, vals[k], want_v[k]); end
            if (edges[k] != want_e[k])  begin miscompares++; $display("FAIL ramp edge[%0d]: got %0d, expected %0d", k, edges[k], want_e[k]); end
        end
    endtask

    // Fill with enable low, refuse a 17th sample, then drain 16 pulses.
    task automatic test_fill();
        int pulses = 0;
        int want;
`ifdef FILTER_FEEDER_PRIME_EN
        want = 13;
`else
        want = 16;
`endif
        enable = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = 8'($urandom);
            cycle();
        end
        vectors += 2;
        if (fifo_level !== LVL_FULL) begin miscompares++; $display("FAIL fill level: got %0d, expected %0d", fifo_level, DEPTH); end
        if (in_ready !== 1'b0)       begin miscompares++; $display("FAIL fill in_ready: got %b, expected 0", in_ready); end
        in_data = 8'($urandom);
        repeat (3) cycle();
        vectors += 2;
        if (fifo_level !== LVL_FULL) begin miscompares++; $display("FAIL fill 17th accepted, level: got %0d, expected %0d", fifo_level, DEPTH); end
        if (in_ready !== 1'b0)       begin miscompares++; $display("FAIL fill held in_ready: got %b, expected 0", in_ready); end
        in_valid = 0; enable = 1;
        for (int i = 0; i < DEPTH + 6; i++) begin
            cycle();
            vectors++;
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL fill out_valid cycle %0d: got %b, expected %b", i, out_valid, m_valid); end
            if (m_valid) begin
                vectors++;
                if (out_data !== 8'(m_data)) begin miscompares++; $display("FAIL fill out_data cycle %0d: got %0d, expected %0d", i, out_data, m_data); end
            end
            if (out_valid === 1'b1) pulses++;
        end
        vectors += 3;
        if (pulses != want)     begin miscompares++; $display("FAIL fill pulse_count: got %0d, expected %0d", pulses, want); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL fill drained in_ready: got %b, expected 1", in_ready); end
        if (fifo_level !== '0)  begin miscompares++; $display("FAIL fill drained level: got %0d, expected 0", fifo_level); end
    endtask

    // Eight samples of 20, enable dropped after the 4th issue for a random gap.
    task automatic test_enable_gap();
        int gap = int'($urandom_range(1, 5));
        int pre = 0;
        int total = 0;
        int want_pre, want_total;
`ifdef FILTER_FEEDER_PRIME_EN
        want_pre = 1; want_total = 2;
`else
        want_pre = 4; want_total = 8;
`endif
        in_valid = 0; enable = 1;
        repeat (4) cycle();
        for (int i = 0; i < 14 + gap; i++) begin
            in_valid = (i < 8);
            in_data  = 8'sd20;
            enable   = !(i >= 5 && i < 5 + gap);
            cycle();
            vectors++;
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL gap%0d out_valid edge %0d: got %b, expected %b", gap, i, out_valid, m_valid); end
            if (m_valid) begin
                vectors++;
                if (out_data !== 8'(m_data)) begin miscompares++; $display("FAIL gap%0d out_data edge %0d: got %0d, expected %0d", gap, i, out_data, m_data); end
            end
            if (out_valid === 1'b1) begin
                total++;
                if (i <= 6) pre++;
            end
        end
        in_valid = 0; enable = 1;
        vectors += 2;
        if (pre != want_pre)     begin miscompares++; $display("FAIL gap pre_pulses: got %0d, expected %0d", pre, want_pre); end
        if (total != want_total) begin miscompares++; $display("FAIL gap total_pulses: got %0d, expected %0d", total, want_total); end
    endtask

    // Push+pop at level 15, fill to 16, then a refused push alongside a pop.
    task automatic test_full_pop();
        enable = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            in_valid = 1; in_data = 8'($urandom);
            cycle();
        end
        vectors++;
        if (fifo_level !== LVL_15) begin miscompares++; $display("FAIL fullpop level15: got %0d, expected %0d", fifo_level, DEPTH - 1); end
        in_valid = 1; in_data = 8'($urandom); enable = 1;
        cycle();
        vectors++;
        if (fifo_level !== LVL_15) begin miscompares++; $display("FAIL fullpop push_and_pop level: got %0d, expected %0d", fifo_level, DEPTH - 1); end
        enable = 0; in_data = 8'($urandom);
        cycle();
        vectors += 2;
        if (fifo_level !== LVL_FULL) begin miscompares++; $display("FAIL fullpop filled level: got %0d, expected %0d", fifo_level, DEPTH); end
        if (in_ready !== 1'b0)       begin miscompares++; $display("FAIL fullpop in_ready: got %b, expected 0", in_ready); end
        in_data = 8'sh55; enable = 1;
        cycle();
        vectors += 2;
        if (fifo_level !== LVL_15) begin miscompares++; $display("FAIL fullpop push_while_full level: got %0d, expected %0d", fifo_level, DEPTH - 1); end
        if (in_ready !== 1'b1)     begin miscompares++; $display("FAIL fullpop after_pop in_ready: got %b, expected 1", in_ready); end
        in_valid = 0;
        for (int i = 0; i < DEPTH + 6; i++) begin
            cycle();
            vectors++;
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL fullpop out_valid cycle %0d: got %b, expected %b", i, out_valid, m_valid); end
            if (m_valid) begin
                vectors++;
                if (out_data !== 8'(m_data)) begin miscompares++; $display("FAIL fullpop out_data cycle %0d: got %0d, expected %0d", i, out_data, m_data); end
            end
        end
        vectors++;
        if (fifo_level !== '0) begin miscompares++; $display("FAIL fullpop drained level: got %0d, expected 0", fifo_level); end
    endtask

    // One-cycle reset with samples queued and issues in flight.
    task automatic test_reset_mid();
        enable = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_data = 8'($urandom);
            cycle();
        end
        in_valid = 0; enable = 1;
        cycle();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        vectors += 3;
        if (flt_start !== 1'b0) begin miscompares++; $display("FAIL rstmid flt_start: got %b, expected 0", flt_start); end
        if (fifo_level !== '0)  begin miscompares++; $display("FAIL rstmid level: got %0d, expected 0", fifo_level); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid out_valid: got %b, expected 0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            cycle();
            vectors += 2;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid late out_valid cycle %0d: got %b, expected 0", i, out_valid); end
            if (flt_start !== 1'b0) begin miscompares++; $display("FAIL rstmid late flt_start cycle %0d: got %b, expected 0", i, flt_start); end
        end
    endtask

    // Random traffic and enable against the reference model.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            enable   = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            cycle();
            vectors += 3;
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL random out_valid cycle %0d: got %b, expected %b", i, out_valid, m_valid); end
            if (fifo_level !== LW'(q.size())) begin miscompares++; $display("FAIL random level cycle %0d: got %0d, expected %0d", i, fifo_level, q.size()); end
            if (in_ready !== (q.size() < DEPTH)) begin miscompares++; $display("FAIL random in_ready cycle %0d: got %b, expected %b", i, in_ready, q.size() < DEPTH); end
            if (m_valid) begin
                vectors++;
                if (out_data !== 8'(m_data)) begin miscompares++; $display("FAIL random out_data cycle %0d: got %0d, expected %0d", i, out_data, m_data); end
            end
        end
        in_valid = 0; enable = 1;
        for (int i = 0; i < DEPTH + 6; i++) begin
            cycle();
            vectors++;
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL random drain out_valid cycle %0d: got %b, expected %b", i, out_valid, m_valid); end
            if (m_valid) begin
                vectors++;
                if (out_data !== 8'(m_data)) begin miscompares++; $display("FAIL random drain out_data cycle %0d: got %0d, expected %0d", i, out_data, m_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_fill();
        test_enable_gap();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
